conv3d_window_gen: RTL and testbench
====================================

# conv3d_window_gen

Streaming window generator that produces the 3D windows consumed by the convolution kernel datapath. It accepts a feature volume one voxel per valid beat, in raster order (column fastest, then row, then slice). It buffers the voxels in a tapped delay line and emits every fully populated KERN_L×KERN_H×KERN_W window as a flattened signed array. Framing matches the kernel's input side (`fin_start`, `din_vld`), so outputs connect directly to the kernel's `fin_start`, `din_vld` and `din`. Valid (unpadded) convolution, stride 1.

## Interface
- `DIN_WIDTH`, 8: voxel width, signed.
- `KERN_H`, 3: window rows.
- `KERN_W`, 3: window columns.
- `KERN_L`, 3: window slices.
- `FM_H`, 8: volume rows, ≥ KERN_H.
- `FM_W`, 8: volume columns, ≥ KERN_W.
- `FM_L`, 8: volume slices, ≥ KERN_L.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fin_start`  in  1  marks the first voxel of a volume; qualified by `din_vld`.
- `din_vld`  in  1  voxel valid.
- `din`  in  DIN_WIDTH  signed voxel.
- `fout_start`  out  1  marks the first window of a volume; qualified by `dout_vld`.
- `dout_vld`  out  1  window valid.
- `dout`  out  [KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][DIN_WIDTH-1:0]  signed window.
- `frame_err`  out  1  sticky framing error; exists only with CONV3D_WIN_FRAME_CHK_EN.

## Operation
- States are IDLE and RUN.
  - IDLE → RUN on `din_vld & fin_start`. That voxel has coordinate (z,y,x) = (0,0,0).
  - RUN → IDLE on acceptance of voxel (FM_L-1, FM_H-1, FM_W-1).
  - In IDLE, beats with `din_vld=1` and `fin_start=0` are dropped.
- `fin_start` with `din_vld=1` in RUN restarts the volume: coordinates return to (0,0,0). Old delay-line data is never output, because validity depends only on the new coordinates.
- `fin_start` with `din_vld=0` is ignored.
- The delay line shifts only on accepted beats. Depth is D = (KERN_L-1)·FM_H·FM_W + (KERN_H-1)·FM_W + KERN_W words. Tap for window element [l][h][w] sits at age (KERN_L-1-l)·FM_H·FM_W + (KERN_H-1-h)·FM_W + (KERN_W-1-w).
- An accepted voxel at (z,y,x) with z≥KERN_L-1, y≥KERN_H-1 and x≥KERN_W-1 completes a window whose origin is (z-KERN_L+1, y-KERN_H+1, x-KERN_W+1). dout[l][h][w] is the voxel at origin+(l,h,w).
- `fout_start` is asserted with the first window of each volume only.
- Windows per volume: (FM_L-KERN_L+1)(FM_H-KERN_H+1)(FM_W-KERN_W+1).
- No arithmetic is performed; samples pass through bit-exact. Coordinate counters are $clog2(FM_x) bits wide.

## Timing
- Latency: a window completed by a beat accepted at edge n gives `dout_vld=1` after edge n+1, for exactly one cycle.
- `dout` is registered and holds its last value while `dout_vld=0`.
- Input gaps of any length are allowed. Output gaps mirror input gaps.
- No backpressure: the downstream side must accept every `dout_vld` beat.
- Reset asserted: state IDLE, counters 0, `dout_vld=0`, `fout_start=0`, `dout=0`, `frame_err=0`. Delay-line storage is not reset.
- Reset mid-volume: outputs clear immediately. The next window requires a fresh `fin_start`.

## Configuration
- `CONV3D_WIN_FRAME_CHK_EN` defined:
  - `frame_err` port exists.
  - It is set on a `din_vld` beat without `fin_start` in IDLE.
  - It is set on `fin_start` in RUN at any coordinate other than (0,0,0).
  - It clears only on reset.
- Undefined: no port and no checking logic. Data behaviour is identical in both builds.

## Structure
- Package `conv3d_pkg` holds:
  - coordinate typedefs;
  - state enum (IDLE, RUN);
  - function `tap_age(l,h,w)` computing delay-line tap ages;
  - localparam for D.
- Sub-module `conv_delay_line` (DEPTH, WIDTH): enable-gated shift register exposing all stages. The top selects taps from it.

## Test plan
- **Base run.** FM 4×4×4, kernel 3×3×3, din = linear index 0..63, continuous valid, fin_start on beat 0.
  - First `dout_vld` follows beat 42, with `fout_start=1`, dout[0][0][0]=0, dout[1][2][0]=24, dout[2][2][2]=42.
  - 8 windows total; last window dout[2][2][2]=63.
- **Gapped input.** Same stimulus with `din_vld` toggling 1/0.
  - Identical 8 windows and contents, each one cycle after its completing beat.
- **Restart mid-volume.** fin_start at beat 20, then a fresh volume.
  - No window from the old data.
  - First window after the 43rd new beat, with fout_start=1 and dout[0][0][0] equal to the new voxel 0.
- **Async reset.** reset_n low for 3 cycles at beat 50.
  - dout_vld, fout_start and dout go to 0 immediately.
  - Voxels without fin_start after release produce no output.
- **Framing check** (macro on). Valid beat without fin_start while IDLE sets frame_err=1 and drops the beat; a later proper volume still yields 8 windows.
- **Back-to-back volumes.** Two 4×4×4 volumes, the second's fin_start on the beat after voxel 63.
  - 16 windows; fout_start on window 1 and window 9.

Source files
------------

// File: rtl/conv3d_pkg.sv
// conv3d_pkg: shared types and geometry helpers for the 3D window generator.
//   - state_e           : window generator FSM states (IDLE, RUN)
//   - *_coord_t         : coordinate types for the default 8x8x8 volume
//   - tap_age()         : delay-line age of window element [l][h][w]
//   - line_depth()      : delay-line depth D for a given geometry
//   - LINE_DEPTH_DEF    : D for the default geometry
package conv3d_pkg;

    localparam int KERN_L_DEF = 3;
    localparam int KERN_H_DEF = 3;
    localparam int KERN_W_DEF = 3;
    localparam int FM_L_DEF   = 8;
    localparam int FM_H_DEF   = 8;
    localparam int FM_W_DEF   = 8;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    typedef logic [$clog2(FM_W_DEF)-1:0] x_coord_t;
    typedef logic [$clog2(FM_H_DEF)-1:0] y_coord_t;
    typedef logic [$clog2(FM_L_DEF)-1:0] z_coord_t;

    // Element [l][h][w] was accepted this many beats before the newest voxel.
    function automatic int tap_age(input int l, input int h, input int w,
                                   input int kern_l, input int kern_h, input int kern_w,
                                   input int fm_h, input int fm_w);
        return (kern_l - 1 - l) * fm_h * fm_w + (kern_h - 1 - h) * fm_w + (kern_w - 1 - w);
    endfunction

    function automatic int line_depth(input int kern_l, input int kern_h, input int kern_w,
                                      input int fm_h, input int fm_w);
        return (kern_l - 1) * fm_h * fm_w + (kern_h - 1) * fm_w + kern_w;
    endfunction

    localparam int LINE_DEPTH_DEF = line_depth(KERN_L_DEF, KERN_H_DEF, KERN_W_DEF,
                                               FM_H_DEF, FM_W_DEF);

endpackage

// File: rtl/conv_delay_line.sv
// conv_delay_line: enable-gated shift register exposing every stage.
//   clk  : clock, rising edge
//   en   : shift when high
//   din  : word entering stage 0
//   taps : all stages, taps[k] holds the word accepted k shifts ago
// Storage is intentionally not reset; consumers qualify it with their own state.
module conv_delay_line #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         en,
    input  logic [WIDTH-1:0]             din,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign taps = stage_q;

endmodule

// File: rtl/conv3d_window_gen.sv
// conv3d_window_gen: streaming KERN_L x KERN_H x KERN_W window generator
// (valid convolution, stride 1) over a raster-ordered FM_L x FM_H x FM_W volume.
//   clk, reset_n          : clock / async active-low reset
//   fin_start, din_vld    : input framing (fin_start qualified by din_vld)
//   din                   : signed voxel
//   fout_start, dout_vld  : output framing, one cycle per window
//   dout                  : registered window, holds while dout_vld=0
//   frame_err             : sticky framing error, only with CONV3D_WIN_FRAME_CHK_EN
module conv3d_window_gen
    import conv3d_pkg::*;
#(
    parameter int DIN_WIDTH = 8,
    parameter int KERN_H    = 3,
    parameter int KERN_W    = 3,
    parameter int KERN_L    = 3,
    parameter int FM_H      = 8,
    parameter int FM_W      = 8,
    parameter int FM_L      = 8
) (
    input  logic                                                     clk,
    input  logic                                                     reset_n,
    input  logic                                                     fin_start,
    input  logic                                                     din_vld,
    input  logic signed [DIN_WIDTH-1:0]                              din,
    output logic                                                     fout_start,
    output logic                                                     dout_vld,
    output logic signed [KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][DIN_WIDTH-1:0] dout
`ifdef CONV3D_WIN_FRAME_CHK_EN
    ,
    output logic                                                     frame_err
`endif
);

    localparam int D  = line_depth(KERN_L, KERN_H, KERN_W, FM_H, FM_W);
    localparam int XW = $clog2(FM_W);
    localparam int YW = $clog2(FM_H);
    localparam int ZW = $clog2(FM_L);

    localparam logic [XW-1:0] X_LAST = XW'(FM_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FM_H - 1);
    localparam logic [ZW-1:0] Z_LAST = ZW'(FM_L - 1);
    localparam logic [XW-1:0] X_MIN  = XW'(KERN_W - 1);
    localparam logic [YW-1:0] Y_MIN  = YW'(KERN_H - 1);
    localparam logic [ZW-1:0] Z_MIN  = ZW'(KERN_L - 1);

    typedef logic [KERN_L-1:0][KERN_H-1:0][KERN_W-1:0][DIN_WIDTH-1:0] win_t;

    state_e          state_q, state_d;
    logic [XW-1:0]   x_q, x_d, cx;
    logic [YW-1:0]   y_q, y_d, cy;
    logic [ZW-1:0]   z_q, z_d, cz;
    logic            first_seen_q, first_seen_d, seen_cur;
    logic            win_pend_q, win_pend_d;
    logic            first_pend_q, first_pend_d;
    logic            dout_vld_q, fout_start_q;
    win_t            dout_q, dout_d, tap_win;
    logic            accept, restart, last_vox, complete;

    logic [D-1:0][DIN_WIDTH-1:0] taps;
    logic                        unused_taps;

    conv_delay_line #(.DEPTH(D), .WIDTH(DIN_WIDTH)) u_line (
        .clk  (clk),
        .en   (accept),
        .din  (din),
        .taps (taps)
    );

    for (genvar l = 0; l < KERN_L; l++) begin : g_l
        for (genvar h = 0; h < KERN_H; h++) begin : g_h
            for (genvar w = 0; w < KERN_W; w++) begin : g_w
                localparam int AGE = tap_age(l, h, w, KERN_L, KERN_H, KERN_W, FM_H, FM_W);
                assign tap_win[l][h][w] = taps[AGE];
            end
        end
    end

    // Most stages are pure delay and never tapped.
    assign unused_taps = ^taps;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = last_vox ? IDLE : RUN;
            RUN:  if (accept && last_vox) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs. A fin_start beat pins the voxel to (0,0,0) in either state.
    always_comb begin
        restart = din_vld & fin_start;
        accept  = din_vld & (fin_start | (state_q == RUN));
    end

    // Coordinates of the current beat and window bookkeeping.
    always_comb begin
        cx       = restart ? '0 : x_q;
        cy       = restart ? '0 : y_q;
        cz       = restart ? '0 : z_q;
        seen_cur = restart ? 1'b0 : first_seen_q;
        last_vox = (cx == X_LAST) && (cy == Y_LAST) && (cz == Z_LAST);
        complete = accept && (cx >= X_MIN) && (cy >= Y_MIN) && (cz >= Z_MIN);

        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        first_seen_d = first_seen_q;
        if (accept) begin
            x_d          = cx + XW'(1);
            y_d          = cy;
            z_d          = cz;
            first_seen_d = seen_cur | complete;
            if (cx == X_LAST) begin
                x_d = '0;
                y_d = cy + YW'(1);
                if (cy == Y_LAST) begin
                    y_d = '0;
                    z_d = (cz == Z_LAST) ? '0 : cz + ZW'(1);
                end
            end
        end

        win_pend_d   = complete;
        first_pend_d = complete & ~seen_cur;

        // The completing voxel is in stage 0 one edge later, so the window is
        // captured from the delay line on the cycle after acceptance.
        dout_d = win_pend_q ? tap_win : dout_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            first_seen_q <= 1'b0;
            win_pend_q   <= 1'b0;
            first_pend_q <= 1'b0;
            dout_vld_q   <= 1'b0;
            fout_start_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            first_seen_q <= first_seen_d;
            win_pend_q   <= win_pend_d;
            first_pend_q <= first_pend_d;
            dout_vld_q   <= win_pend_q;
            fout_start_q <= first_pend_q;
            dout_q       <= dout_d;
        end
    end

    assign dout_vld   = dout_vld_q;
    assign fout_start = fout_start_q;
    assign dout       = dout_q;

`ifdef CONV3D_WIN_FRAME_CHK_EN
    logic frame_err_q, frame_err_d;

    always_comb begin
        frame_err_d = frame_err_q
                    | (din_vld & ~fin_start & (state_q == IDLE))
                    | (restart & (state_q == RUN) & ((x_q != '0) | (y_q != '0) | (z_q != '0)));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_err_q <= 1'b0;
        else          frame_err_q <= frame_err_d;
    end

    assign frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_conv3d_window_gen.sv
// tb_conv3d_window_gen: directed, table-driven bench for conv3d_window_gen
// on a 4x4x4 volume with a 3x3x3 kernel. frame_err is checked when
// CONV3D_WIN_FRAME_CHK_EN is defined.
module tb_conv3d_window_gen;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int FM = 4;

    typedef logic [K-1:0][K-1:0][K-1:0][DW-1:0] win_t;
    typedef struct { int beat; int origin; bit fs; } vec_t;
    typedef struct { int cyc; logic fs; win_t d; } obs_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          fin_start = 1'b0;
    logic          din_vld = 1'b0;
    logic [DW-1:0] din = '0;
    logic          fout_start;
    logic          dout_vld;
    win_t          dout;
`ifdef CONV3D_WIN_FRAME_CHK_EN
    logic          frame_err;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    obs_t obs_q[$];
    int   beat_edge[$];
    vec_t tbl[8];

    conv3d_window_gen #(
        .DIN_WIDTH(DW), .KERN_H(K), .KERN_W(K), .KERN_L(K),
        .FM_H(FM), .FM_W(FM), .FM_L(FM)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fin_start  (fin_start),
        .din_vld    (din_vld),
        .din        (din),
        .fout_start (fout_start),
        .dout_vld   (dout_vld),
        .dout       (dout)
`ifdef CONV3D_WIN_FRAME_CHK_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dout_vld === 1'b1) obs_q.push_back('{cyc, fout_start, dout});
    end

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_win(input string name, input win_t act, input win_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_beat(input logic fs, input logic [DW-1:0] val);
        @(negedge clk);
        fin_start = fs;
        din_vld   = 1'b1;
        din       = val;
        beat_edge.push_back(cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din_vld   = 1'b0;
            fin_start = 1'b0;
        end
    endtask

    task automatic send_vol(input int base, input bit gapped);
        for (int i = 0; i < FM*FM*FM; i++) begin
            drive_beat(i == 0, DW'(base + i));
            if (gapped) idle(1);
        end
    endtask

    task automatic clear_logs();
        obs_q.delete();
        beat_edge.delete();
    endtask

    // Compare 8 observed windows (starting at win_ofs) against the table.
    // Voxel value at (z,y,x) is base + 16z + 4y + x.
    task automatic check_volume(input string name, input int base, input int beat_ofs,
                                input int win_ofs);
        for (int i = 0; i < 8; i++) begin
            win_t e;
            int   k = win_ofs + i;
            for (int l = 0; l < K; l++)
                for (int h = 0; h < K; h++)
                    for (int w = 0; w < K; w++)
                        e[l][h][w] = DW'(base + tbl[i].origin + FM*FM*l + FM*h + w);
            if (k >= obs_q.size()) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s win%0d: missing, got %0d windows expected at least %0d",
                         name, i, obs_q.size(), k + 1);
            end else begin
                chk_win($sformatf("%s win%0d data", name, i), obs_q[k].d, e);
                chk_bit($sformatf("%s win%0d fout_start", name, i), obs_q[k].fs, tbl[i].fs);
                chk_int($sformatf("%s win%0d cycle", name, i), obs_q[k].cyc,
                        beat_edge[beat_ofs + tbl[i].beat] + 1);
            end
        end
    endtask

    initial begin
        win_t w0;

        // completing beat, window origin value, first-window flag
        tbl[0] = '{42,  0, 1'b1};
        tbl[1] = '{43,  1, 1'b0};
        tbl[2] = '{46,  4, 1'b0};
        tbl[3] = '{47,  5, 1'b0};
        tbl[4] = '{58, 16, 1'b0};
        tbl[5] = '{59, 17, 1'b0};
        tbl[6] = '{62, 20, 1'b0};
        tbl[7] = '{63, 21, 1'b0};

        // Reset state
        #12;
        chk_bit("reset dout_vld", dout_vld, 1'b0);
        chk_bit("reset fout_start", fout_start, 1'b0);
        chk_win("reset dout", dout, '0);
`ifdef CONV3D_WIN_FRAME_CHK_EN
        chk_bit("reset frame_err", frame_err, 1'b0);
`endif
        @(negedge clk);
        reset_n = 1'b1;

        // Base run
        clear_logs();
        send_vol(0, 1'b0);
        idle(4);
        chk_int("base count", obs_q.size(), 8);
        if (obs_q.size() > 0) begin
            w0 = obs_q[0].d;
            chk_int("base first d000", int'(w0[0][0][0]), 0);
            chk_int("base first d120", int'(w0[1][2][0]), 24);
            chk_int("base first d222", int'(w0[2][2][2]), 42);
        end
        if (obs_q.size() == 8) begin
            w0 = obs_q[7].d;
            chk_int("base last d222", int'(w0[2][2][2]), 63);
        end
        check_volume("base", 0, 0, 0);

        // Gapped input
        clear_logs();
        send_vol(0, 1'b1);
        idle(4);
        chk_int("gap count", obs_q.size(), 8);
        check_volume("gap", 0, 0, 0);

        // Stray beat in IDLE is dropped, then a proper volume
        clear_logs();
        drive_beat(1'b0, 8'd99);
        idle(3);
        chk_int("stray count", obs_q.size(), 0);
`ifdef CONV3D_WIN_FRAME_CHK_EN
        chk_bit("stray frame_err", frame_err, 1'b1);
`endif
        send_vol(0, 1'b0);
        idle(4);
        chk_int("stray vol count", obs_q.size(), 8);
        check_volume("stray vol", 0, 1, 0);

        // Restart mid-volume at beat 20
        clear_logs();
        for (int i = 0; i < 20; i++) drive_beat(i == 0, DW'(i));
        send_vol(64, 1'b0);
        idle(4);
        chk_int("restart count", obs_q.size(), 8);
        check_volume("restart", 64, 20, 0);

        // Back-to-back volumes
        clear_logs();
        send_vol(0, 1'b0);
        send_vol(64, 1'b0);
        idle(4);
        chk_int("b2b count", obs_q.size(), 16);
        check_volume("b2b vol1", 0, 0, 0);
        check_volume("b2b vol2", 64, 64, 8);

        // Async reset at beat 50
        clear_logs();
        for (int i = 0; i <= 50; i++) drive_beat(i == 0, DW'(i));
        @(negedge clk);
        din_vld   = 1'b0;
        fin_start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_bit("areset dout_vld", dout_vld, 1'b0);
        chk_bit("areset fout_start", fout_start, 1'b0);
        chk_win("areset dout", dout, '0);
`ifdef CONV3D_WIN_FRAME_CHK_EN
        chk_bit("areset frame_err", frame_err, 1'b0);
`endif
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        for (int i = 0; i < FM*FM*FM; i++) drive_beat(1'b0, DW'(i));
        idle(4);
        chk_int("post-reset no fin_start count", obs_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
